// File: rtl/muldiv_sequencer_pkg.sv
// Shared RV32M execution-unit definitions.
//   XLEN            default operand/result width
//   muldiv_op_e     funct3 encodings of the M-extension ops
//   muldiv_state_e  sequencer FSM states
//   op_signed_a/b   which operands are interpreted as two's complement
//   op_is_div       divide/remainder family versus multiply family
package cpu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    function automatic logic op_signed_a(muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_signed_b(muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_is_div(muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the multi-cycle M unit.
//   req_valid/req_ready  request handshake carrying funct3, rs1_data, rs2_data
//   rsp_valid/rsp_ready  response handshake carrying rsp_data
//   busy                 unit occupied; the hazard unit stalls EX on it
// master = EX stage (issuer), slave = muldiv_sequencer.
interface muldiv_sequencer_if #(
    parameter int XLEN = cpu_pkg::XLEN
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            busy;

    modport master (
        output req_valid, funct3, rs1_data, rs2_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, funct3, rs1_data, rs2_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the magnitude loop.
//   is_div   1 = restoring divide step, 0 = shift-add multiply step
//   acc_in   upper half: partial product (mul) / partial remainder (div)
//   lo_in    lower half: multiplier bits being consumed (mul) /
//            dividend bits being consumed, quotient bits entering (div)
//   opnd     multiplicand magnitude (mul) / divisor magnitude (div)
//   acc_out, lo_out  state after this iteration
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc_in,
    input  logic [XLEN-1:0] lo_in,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] acc_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] trial;

    always_comb begin
        // Multiply: add multiplicand when the low multiplier bit is set, then
        // shift the whole {acc, lo} pair right so the carry lands in acc.
        sum = {1'b0, acc_in} + {1'b0, (lo_in[0] ? opnd : '0)};

        // Divide: the XLEN+1-bit remainder accumulator is the previous
        // remainder with the next dividend bit shifted in. When it fits, the
        // difference is below the divisor, so XLEN bits of it are exact.
        shifted = {acc_in, lo_in[XLEN-1]};
        fits    = shifted >= {1'b0, opnd};
        trial   = shifted[XLEN-1:0] - opnd;

        if (is_div) begin
            acc_out = fits ? trial : shifted[XLEN-1:0];
            lo_out  = {lo_in[XLEN-2:0], fits};
        end else begin
            acc_out = sum[XLEN:1];
            lo_out  = {sum[0], lo_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M execution unit beside the EX-stage ALU.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   flush  synchronous kill of the in-flight op (branch/trap), highest priority
//   bus    slave side of muldiv_sequencer_if (request, response, busy)
// Operands are reduced to magnitudes on accept, an XLEN-step loop runs in CALC,
// FIX restores signs and selects the result, DONE holds it until accepted.
// Divide-by-zero and signed overflow bypass the loop and go straight to DONE.
module muldiv_sequencer
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    muldiv_sequencer_if.slave    bus
);

    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    muldiv_state_e   state, state_nxt;
    logic [CW-1:0]   count;

    logic            req_ready_c, busy_c, rsp_valid_c, load_fix;
    logic            accept;

    muldiv_op_e      op_in, op_q;
    logic            sa_in, sb_in, sa_q, sb_q;
    logic [XLEN-1:0] mag_a, mag_b;

    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    logic [XLEN-1:0] acc_q, lo_q, opnd_q;
    logic [XLEN-1:0] acc_nxt, lo_nxt;

    logic [2*XLEN-1:0] product, product_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;
    logic [XLEN-1:0]   rsp_data_q;

    // ---------------------------------------------------------------
    // Request decode: magnitudes and the loop-free special cases
    // ---------------------------------------------------------------
    always_comb begin
        op_in = muldiv_op_e'(bus.funct3);
        sa_in = op_signed_a(op_in) && bus.rs1_data[XLEN-1];
        sb_in = op_signed_b(op_in) && bus.rs2_data[XLEN-1];
        mag_a = sa_in ? -bus.rs1_data : bus.rs1_data;
        mag_b = sb_in ? -bus.rs2_data : bus.rs2_data;

        div_zero = op_is_div(op_in) && (bus.rs2_data == '0);
        div_ovf  = (op_in inside {OP_DIV, OP_REM}) &&
                   (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (bus.rs2_data == '1);
        special  = div_zero || div_ovf;

        // funct3[1] separates REM* from DIV* within the divide family.
        if (div_zero)
            special_res = bus.funct3[1] ? bus.rs1_data : '1;
        else if (div_ovf)
            special_res = bus.funct3[1] ? '0 : bus.rs1_data;
        else
            special_res = '0;
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (accept) state_nxt = special ? DONE : CALC;
                CALC: if (count == LAST) state_nxt = FIX;
                FIX:  state_nxt = DONE;
                DONE: if (bus.rsp_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        req_ready_c = (state == IDLE) && !flush;
        busy_c      = (state != IDLE);
        rsp_valid_c = (state == DONE);
        load_fix    = (state == FIX) && !flush;
    end

    assign accept        = bus.req_valid && req_ready_c;
    assign bus.req_ready = req_ready_c;
    assign bus.busy      = busy_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_data  = rsp_data_q;

    // ---------------------------------------------------------------
    // Step counter: zero everywhere outside CALC, stops at XLEN-1
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (flush || state != CALC || count == LAST)
            count <= '0;
        else
            count <= count + CW'(1);
    end

    // ---------------------------------------------------------------
    // Operand / loop registers (datapath, not reset)
    // ---------------------------------------------------------------
    muldiv_step #(XLEN) u_step (
        .is_div  (op_is_div(op_q)),
        .acc_in  (acc_q),
        .lo_in   (lo_q),
        .opnd    (opnd_q),
        .acc_out (acc_nxt),
        .lo_out  (lo_nxt)
    );

    // Mul: lo starts as the multiplier, opnd is the multiplicand.
    // Div: lo starts as the dividend, opnd is the divisor.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= op_in;
            sa_q   <= sa_in;
            sb_q   <= sb_in;
            acc_q  <= '0;
            lo_q   <= op_is_div(op_in) ? mag_a : mag_b;
            opnd_q <= op_is_div(op_in) ? mag_b : mag_a;
        end else if (state == CALC) begin
            acc_q  <= acc_nxt;
            lo_q   <= lo_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Sign correction and result select
    // ---------------------------------------------------------------
    always_comb begin
        product   = {acc_q, lo_q};
        product_s = (sa_q ^ sb_q) ? -product : product;
        quo_s     = (sa_q ^ sb_q) ? -lo_q : lo_q;
        rem_s     = sa_q ? -acc_q : acc_q;
        unique case (op_q)
            OP_MUL:                        fix_res = product_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = product_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_res = quo_s;
            default:                       fix_res = rem_s;
        endcase
    end

    // ---------------------------------------------------------------
    // Response register: loaded on a special-case accept or in FIX
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_data_q <= '0;
        else if (accept && special)
            rsp_data_q <= special_res;
        else if (load_fix)
            rsp_data_q <= fix_res;
    end

endmodule
